// File: rtl/cfg_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : cfg_spi_slave
// Brief   : Mode-0 SPI slave driving single-cycle writes and read-back on the
//           parallel config bus. Define CFG_SPI_PARITY_EN for a trailing
//           even-parity bit per frame (default build: no parity).
// Revision: 1.0 - initial release
// ============================================================================
module cfg_spi_slave #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic [DATA_W-1:0] i_cfg_rdata,
    output logic              o_cfg_we,
    output logic [ADDR_W-1:0] o_cfg_addr,
    output logic [DATA_W-1:0] o_cfg_data_in,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int c_MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_CNT_W = $clog2(c_MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
`ifdef CFG_SPI_PARITY_EN
        S_PAR  = 3'd4,
`endif
        S_HOLD = 3'd5
    } state_t;

    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_cs_s1, r_cs_s2, r_cs_d, r_cs_armed;
    logic r_mosi_s1, r_mosi_s2;

    logic w_sclk_rise, w_sclk_fall, w_cs_fall;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_cmd;
    logic [ADDR_W-1:0]   r_addr_sh;
    logic [DATA_W-1:0]   r_data_sh;
    logic [DATA_W-1:0]   r_tx;
    logic                r_hold_entry;
    logic                r_addr_done;
    logic                r_rd_pend1;
    logic                r_rd_pend2;
    logic                r_we;
    logic [ADDR_W-1:0]   r_cfg_addr;
    logic [DATA_W-1:0]   r_cfg_data;
`ifdef CFG_SPI_PARITY_EN
    logic                r_par;
    logic                r_frame_err;
`endif

    // The cs_n chain resets to "low" and r_cs_armed to 0, so a frame already in
    // progress when reset is released is never mistaken for a new cs_n fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_sclk_d   <= 1'b0;
            r_cs_s1    <= 1'b0;
            r_cs_s2    <= 1'b0;
            r_cs_d     <= 1'b0;
            r_cs_armed <= 1'b0;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
        end else begin
            r_sclk_s1  <= i_sclk;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_d   <= r_sclk_s2;
            r_cs_s1    <= i_cs_n;
            r_cs_s2    <= r_cs_s1;
            r_cs_d     <= r_cs_s2;
            r_cs_armed <= r_cs_armed | r_cs_s2;
            r_mosi_s1  <= i_mosi;
            r_mosi_s2  <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cmd        <= 1'b0;
            r_addr_sh    <= '0;
            r_data_sh    <= '0;
            r_tx         <= '0;
            r_hold_entry <= 1'b0;
            r_addr_done  <= 1'b0;
            r_rd_pend1   <= 1'b0;
            r_rd_pend2   <= 1'b0;
            r_we         <= 1'b0;
            r_cfg_addr   <= '0;
            r_cfg_data   <= '0;
`ifdef CFG_SPI_PARITY_EN
            r_par        <= 1'b0;
            r_frame_err  <= 1'b0;
`endif
        end else begin
            r_we         <= 1'b0;
            r_hold_entry <= 1'b0;
            r_addr_done  <= 1'b0;
            r_rd_pend1   <= 1'b0;
            r_rd_pend2   <= r_rd_pend1;

            if (r_cs_s2) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                            r_tx    <= '0;
`ifdef CFG_SPI_PARITY_EN
                            r_par   <= 1'b0;
`endif
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd   <= r_mosi_s2;
                            r_state <= S_ADDR;
                            r_cnt   <= '0;
`ifdef CFG_SPI_PARITY_EN
                            r_par   <= r_par ^ r_mosi_s2;
`endif
                        end
                    end
                    S_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr_sh <= {r_addr_sh[ADDR_W-2:0], r_mosi_s2};
`ifdef CFG_SPI_PARITY_EN
                            r_par     <= r_par ^ r_mosi_s2;
`endif
                            if (r_cnt == c_CNT_W'(ADDR_W - 1)) begin
                                r_state     <= S_DATA;
                                r_cnt       <= '0;
                                r_addr_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_sclk_rise) begin
                            r_data_sh <= {r_data_sh[DATA_W-2:0], r_mosi_s2};
`ifdef CFG_SPI_PARITY_EN
                            r_par     <= r_par ^ r_mosi_s2;
`endif
                            if (r_cnt == c_CNT_W'(DATA_W - 1)) begin
                                r_cnt <= '0;
`ifdef CFG_SPI_PARITY_EN
                                r_state      <= S_PAR;
`else
                                r_state      <= S_HOLD;
                                r_hold_entry <= 1'b1;
`endif
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end
`ifdef CFG_SPI_PARITY_EN
                    S_PAR: begin
                        if (w_sclk_rise) begin
                            r_par        <= r_par ^ r_mosi_s2;
                            r_state      <= S_HOLD;
                            r_hold_entry <= 1'b1;
                        end
                    end
`endif
                    S_HOLD: begin
                        r_state <= S_HOLD;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end

            // Read: address is presented first, the muxed data is captured
            // two clocks later once the register mux has settled.
            if (r_addr_done && !r_cmd) begin
                r_cfg_addr <= r_addr_sh;
                r_rd_pend1 <= 1'b1;
            end

            if (r_rd_pend2 && (r_state == S_DATA)) begin
                r_tx <= i_cfg_rdata;
            end else if (w_sclk_fall && (r_state == S_DATA) && (r_cnt != '0)) begin
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end

            if (r_hold_entry) begin
`ifdef CFG_SPI_PARITY_EN
                if (r_par) begin
                    r_frame_err <= 1'b1;
                end else if (r_cmd) begin
                    r_we       <= 1'b1;
                    r_cfg_addr <= r_addr_sh;
                    r_cfg_data <= r_data_sh;
                end
`else
                if (r_cmd) begin
                    r_we       <= 1'b1;
                    r_cfg_addr <= r_addr_sh;
                    r_cfg_data <= r_data_sh;
                end
`endif
            end
        end
    end

    assign o_miso        = (r_state == S_DATA) & ~r_cmd & r_tx[DATA_W-1];
    assign o_cfg_we      = r_we;
    assign o_cfg_addr    = r_cfg_addr;
    assign o_cfg_data_in = r_cfg_data;
    assign o_busy        = ~r_cs_s2 & r_cs_armed;
`ifdef CFG_SPI_PARITY_EN
    assign o_frame_err   = r_frame_err;
`else
    assign o_frame_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_cfg_spi_slave
// Brief   : Directed self-checking bench for cfg_spi_slave (SPI at clk/10).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cfg_spi_slave;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [15:0] cfg_rdata;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data_in;
    logic        busy;
    logic        frame_err;

    int          total;
    int          bad;
    int          cyc;
    int          last_rise_cyc;
    int          we_cnt;
    int          we_cyc;
    logic [4:0]  we_addr;
    logic [15:0] we_data;
    logic        miso_hdr;
    logic [15:0] rd;
    int          w0;

    cfg_spi_slave #(.DATA_W(16), .ADDR_W(5)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sclk        (sclk),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .i_cfg_rdata   (cfg_rdata),
        .o_cfg_we      (cfg_we),
        .o_cfg_addr    (cfg_addr),
        .o_cfg_data_in (cfg_data_in),
        .o_busy        (busy),
        .o_frame_err   (frame_err)
    );

    // Config register mux model
    assign cfg_rdata = (cfg_addr == 5'd7) ? 16'h1234 : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        we_cnt  = 0;
        we_cyc  = 0;
        we_addr = '0;
        we_data = '0;
    end
    always @(negedge clk) begin
        if (cfg_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            we_cyc  = cyc;
            we_addr = cfg_addr;
            we_data = cfg_data_in;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        repeat (5) tick();
        m = miso;
        sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (5) tick();
        sclk = 1'b0;
    endtask

    task automatic frame(input logic cmd, input logic [4:0] a, input logic [15:0] d,
                         input int ndata, input logic bad_par, input int gap,
                         output logic [15:0] rdat);
        logic m;
        rdat = '0;
        miso_hdr = 1'b0;
        cs_n = 1'b0;
        tick();
        chk("busy_rise_early", {31'd0, busy}, 32'd0);
        tick();
        chk("busy_rise", {31'd0, busy}, 32'd1);
        send_bit(cmd, m);
        miso_hdr = miso_hdr | m;
        for (int i = 4; i >= 0; i--) begin
            send_bit(a[i], m);
            miso_hdr = miso_hdr | m;
        end
        for (int i = 15; i >= 16 - ndata; i--) begin
            send_bit(d[i], m);
            rdat[i] = m;
        end
`ifdef CFG_SPI_PARITY_EN
        if (ndata == 16) send_bit((^{cmd, a, d}) ^ bad_par, m);
`endif
        repeat (3) tick();
        cs_n = 1'b1;
        tick();
        chk("busy_fall_early", {31'd0, busy}, 32'd1);
        tick();
        chk("busy_fall", {31'd0, busy}, 32'd0);
        repeat (gap - 2) tick();
    endtask

    initial begin
        logic m;
        total = 0;
        bad   = 0;
        last_rise_cyc = 0;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (3) tick();
        chk("rst_we",   {31'd0, cfg_we}, 32'd0);
        chk("rst_addr", {27'd0, cfg_addr}, 32'd0);
        chk("rst_data", {16'd0, cfg_data_in}, 32'd0);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();

        // Write 0x03 <= 0xA5C3
        w0 = we_cnt;
        frame(1'b1, 5'h03, 16'hA5C3, 16, 1'b0, 6, rd);
        chk("wr_cnt",  we_cnt, w0 + 1);
        chk("wr_addr", {27'd0, we_addr}, 32'h03);
        chk("wr_data", {16'd0, we_data}, 32'hA5C3);
        chk("wr_lat",  we_cyc, last_rise_cyc + 4);
        chk("wr_hold_data", {16'd0, cfg_data_in}, 32'hA5C3);

        // Read 0x07 -> 0x1234
        w0 = we_cnt;
        frame(1'b0, 5'h07, 16'h0000, 16, 1'b0, 6, rd);
        chk("rd_miso",  {16'd0, rd}, 32'h1234);
        chk("rd_no_we", we_cnt, w0);
        chk("rd_addr",  {27'd0, cfg_addr}, 32'h07);
        chk("rd_hdr_miso", {31'd0, miso_hdr}, 32'd0);
        chk("rd_keep_data", {16'd0, cfg_data_in}, 32'hA5C3);
        chk("rd_idle_miso", {31'd0, miso}, 32'd0);

        // Abort after 10 data bits, then a good frame
        w0 = we_cnt;
        frame(1'b1, 5'h05, 16'hBEEF, 10, 1'b0, 6, rd);
        chk("abort_no_we", we_cnt, w0);
        chk("abort_addr",  {27'd0, cfg_addr}, 32'h07);
        frame(1'b1, 5'h01, 16'h00FF, 16, 1'b0, 6, rd);
        chk("post_abort_cnt",  we_cnt, w0 + 1);
        chk("post_abort_addr", {27'd0, we_addr}, 32'h01);
        chk("post_abort_data", {16'd0, we_data}, 32'h00FF);

        // Reset during the address phase
        w0 = we_cnt;
        cs_n = 1'b0;
        repeat (2) tick();
        send_bit(1'b1, m);
        send_bit(1'b0, m);
        send_bit(1'b1, m);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   {31'd0, cfg_we}, 32'd0);
        chk("mid_rst_addr", {27'd0, cfg_addr}, 32'd0);
        chk("mid_rst_data", {16'd0, cfg_data_in}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_miso", {31'd0, miso}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b0, m);
        for (int i = 0; i < 16; i++) send_bit(i[0], m);
`ifdef CFG_SPI_PARITY_EN
        send_bit(1'b0, m);
`endif
        repeat (6) tick();
        cs_n = 1'b1;
        repeat (6) tick();
        chk("mid_rst_no_we", we_cnt, w0);
        chk("mid_rst_hold_addr", {27'd0, cfg_addr}, 32'd0);
        frame(1'b1, 5'h1F, 16'hFFFF, 16, 1'b0, 6, rd);
        chk("post_rst_cnt",  we_cnt, w0 + 1);
        chk("post_rst_addr", {27'd0, we_addr}, 32'h1F);
        chk("post_rst_data", {16'd0, we_data}, 32'hFFFF);

        // Back-to-back writes with a 4 clk cs_n gap
        w0 = we_cnt;
        frame(1'b1, 5'h02, 16'h0001, 16, 1'b0, 4, rd);
        chk("b2b1_cnt",  we_cnt, w0 + 1);
        chk("b2b1_data", {16'd0, we_data}, 32'h0001);
        frame(1'b1, 5'h02, 16'h0002, 16, 1'b0, 4, rd);
        chk("b2b2_cnt",  we_cnt, w0 + 2);
        chk("b2b2_addr", {27'd0, we_addr}, 32'h02);
        chk("b2b2_data", {16'd0, we_data}, 32'h0002);

`ifdef CFG_SPI_PARITY_EN
        w0 = we_cnt;
        frame(1'b1, 5'h04, 16'h8000, 16, 1'b1, 6, rd);
        chk("par_bad_no_we", we_cnt, w0);
        chk("par_bad_ferr",  {31'd0, frame_err}, 32'd1);
        frame(1'b1, 5'h04, 16'h8000, 16, 1'b0, 6, rd);
        chk("par_ok_cnt",  we_cnt, w0 + 1);
        chk("par_ok_addr", {27'd0, we_addr}, 32'h04);
        chk("par_ok_data", {16'd0, we_data}, 32'h8000);
        chk("par_ok_ferr", {31'd0, frame_err}, 32'd1);
`else
        chk("no_par_ferr", {31'd0, frame_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
